// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM (1-cycle read latency) between fetch and data requesters.
// Optional usage counters are built only when ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int RAM_AW     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_wen,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    input  logic              cancel,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_dm_cnt,
    output logic [31:0]       stat_conf_cnt
);

    // Handshake: a requester holds req with stable payload until its gnt is high in a cycle;
    // the access is accepted in that cycle and read data returns with rvalid one cycle later.
    typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_DM} rsp_sel_t;

    rsp_sel_t   rsp_sel, rsp_next;
    logic [3:0] starve_cnt, starve_next;
    logic       fetch_pri;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                                dm_addr[31:RAM_AW+2], dm_addr[1:0]};

    assign fetch_pri = (starve_cnt >= 4'(STARVE_MAX));

    // Grants are forced low while reset is asserted so the RAM sees no access.
    always_comb begin
        dm_gnt = resetn & dm_req & ~(if_req & fetch_pri);
        if_gnt = resetn & if_req & ~dm_gnt;
    end

    always_comb begin
        ram_en    = if_gnt | dm_gnt;
        ram_wen   = 4'b0000;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        if (dm_gnt) begin
            ram_wen   = dm_wen;
            ram_addr  = dm_addr[RAM_AW+1:2];
            ram_wdata = dm_wdata;
        end else if (if_gnt) begin
            ram_addr  = if_addr[RAM_AW+1:2];
        end
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (if_gnt && !cancel) begin
            rsp_next = RSP_IF;
        end else if (dm_gnt && (dm_wen == 4'b0000)) begin
            rsp_next = RSP_DM;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (!if_req || if_gnt) begin
            starve_next = 4'd0;
        end else if (starve_cnt != 4'd15) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_sel    <= RSP_NONE;
            starve_cnt <= 4'd0;
        end else begin
            rsp_sel    <= rsp_next;
            starve_cnt <= starve_next;
        end
    end

    // A fetch response landing in a flush cycle belongs to the wrong path and is dropped.
    assign if_rvalid = (rsp_sel == RSP_IF) & ~cancel;
    assign dm_rvalid = (rsp_sel == RSP_DM);
    assign if_rdata  = ram_rdata;
    assign dm_rdata  = ram_rdata;

`ifdef ARB_STATS_EN
    logic [31:0] if_cnt, dm_cnt, conf_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_cnt   <= 32'd0;
            dm_cnt   <= 32'd0;
            conf_cnt <= 32'd0;
        end else begin
            if (if_gnt)            if_cnt   <= if_cnt + 32'd1;
            if (dm_gnt)            dm_cnt   <= dm_cnt + 32'd1;
            if (if_req && dm_req)  conf_cnt <= conf_cnt + 32'd1;
        end
    end

    assign stat_if_cnt   = if_cnt;
    assign stat_dm_cnt   = dm_cnt;
    assign stat_conf_cnt = conf_cnt;

`ifndef SYNTHESIS
    logic        if_wait, dm_wait;
    logic [31:0] if_addr_q, dm_addr_q;
    logic [3:0]  dm_wen_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_wait   <= 1'b0;
            dm_wait   <= 1'b0;
            if_addr_q <= 32'd0;
            dm_addr_q <= 32'd0;
            dm_wen_q  <= 4'd0;
        end else begin
            if (if_wait && if_req)
                assert (if_addr == if_addr_q) else $error("fetch address changed while waiting");
            if (dm_wait && dm_req)
                assert (dm_addr == dm_addr_q && dm_wen == dm_wen_q)
                    else $error("data request changed while waiting");
            if_wait   <= if_req & ~if_gnt;
            dm_wait   <= dm_req & ~dm_gnt;
            if_addr_q <= if_addr;
            dm_addr_q <= dm_addr;
            dm_wen_q  <= dm_wen;
        end
    end
`endif
`else
    assign stat_if_cnt   = 32'd0;
    assign stat_dm_cnt   = 32'd0;
    assign stat_conf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-level reference of the arbitration rules.
// Counter checks follow ARB_STATS_EN in the same way as the design.
module tb_mem_port_arbiter;

    localparam int RAM_AW     = 8;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req = 1'b0;
    logic [3:0]        dm_wen = 4'd0;
    logic [31:0]       dm_addr = 32'd0;
    logic [31:0]       dm_wdata = 32'd0;
    logic              dm_gnt, dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              cancel = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic [31:0]       stat_if_cnt, stat_dm_cnt, stat_conf_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .cancel(cancel),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt), .stat_conf_cnt(stat_conf_cnt)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // RAM environment driven by the DUT's RAM port.
    logic [31:0] ram_mem [0:DEPTH-1];
    bit          ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
            ram_loaded = 1'b1;
        end
        if (ram_en) begin
            if (ram_wen == 4'b0000) ram_rdata <= ram_mem[ram_addr];
            else ram_mem[ram_addr] = merge(ram_mem[ram_addr], ram_wdata, ram_wen);
        end
    end

    // Reference state.
    logic [31:0] exp_mem [0:DEPTH-1];
    logic [31:0] exp_q[$];
    int          pend_kind;
    int          starve;
    logic [31:0] n_if, n_dm, n_conf;
    bit          e_if_gnt, e_dm_gnt;
    int          req_pct;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        pend_kind = 0;
        starve    = 0;
        exp_q.delete();
        n_if   = 32'd0;
        n_dm   = 32'd0;
        n_conf = 32'd0;
    endtask

    task automatic check_stats();
`ifdef ARB_STATS_EN
        check("stat_if", stat_if_cnt, n_if);
        check("stat_dm", stat_dm_cnt, n_dm);
        check("stat_conf", stat_conf_cnt, n_conf);
`else
        check("stat_if", stat_if_cnt, 32'd0);
        check("stat_dm", stat_dm_cnt, 32'd0);
        check("stat_conf", stat_conf_cnt, 32'd0);
`endif
    endtask

    task automatic check_cycle();
        bit          e_ifv, e_dmv;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wen;
        e_dm_gnt = dm_req && !(if_req && (starve >= STARVE_MAX));
        e_if_gnt = if_req && !e_dm_gnt;
        e_addr   = e_dm_gnt ? 32'(word_idx(dm_addr)) : (e_if_gnt ? 32'(word_idx(if_addr)) : 32'd0);
        e_wdata  = e_dm_gnt ? dm_wdata : 32'd0;
        e_wen    = e_dm_gnt ? dm_wen : 4'd0;
        check("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        check("dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
        check("ram_en", 32'(ram_en), 32'(e_if_gnt || e_dm_gnt));
        check("ram_addr", 32'(ram_addr), e_addr);
        check("ram_wen", 32'(ram_wen), 32'(e_wen));
        check("ram_wdata", ram_wdata, e_wdata);
        e_ifv = (pend_kind == 1) && !cancel;
        e_dmv = (pend_kind == 2);
        check("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        check("dm_rvalid", 32'(dm_rvalid), 32'(e_dmv));
        if (e_ifv && exp_q.size() > 0) check("if_rdata", if_rdata, exp_q[0]);
        if (e_dmv && exp_q.size() > 0) check("dm_rdata", dm_rdata, exp_q[0]);
        check_stats();
    endtask

    task automatic update_model();
        if (pend_kind != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        pend_kind = 0;
        if (e_if_gnt && !cancel) begin
            pend_kind = 1;
            exp_q.push_back(exp_mem[word_idx(if_addr)]);
        end
        if (e_dm_gnt) begin
            if (dm_wen == 4'b0000) begin
                pend_kind = 2;
                exp_q.push_back(exp_mem[word_idx(dm_addr)]);
            end else begin
                exp_mem[word_idx(dm_addr)] = merge(exp_mem[word_idx(dm_addr)], dm_wdata, dm_wen);
            end
        end
        if (!if_req || e_if_gnt) starve = 0;
        else if (starve < 15) starve++;
        if (e_if_gnt) n_if++;
        if (e_dm_gnt) n_dm++;
        if (if_req && dm_req) n_conf++;
    endtask

    task automatic next_stim();
        if (!if_req || e_if_gnt) begin
            if_req  = ($urandom_range(99) < req_pct);
            if_addr = $urandom;
        end
        if (!dm_req || e_dm_gnt) begin
            dm_req   = ($urandom_range(99) < req_pct);
            dm_addr  = $urandom;
            dm_wen   = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
            dm_wdata = $urandom;
        end
        cancel = ($urandom_range(99) < 15);
    endtask

    task automatic do_cycle(input bit auto_stim);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
        if (auto_stim) next_stim();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
        reset_model();
        req_pct = 50;

        // Reset asserted with both requests pending: nothing may be granted.
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h40;
        #12;
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check_stats();
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Single fetch at 0x10, then its response.
        if_req = 1'b1; if_addr = 32'h10;
        do_cycle(0);
        if_req = 1'b0;
        do_cycle(0);

        // Partial store at 0x20: no response afterwards.
        dm_req = 1'b1; dm_wen = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hAABBCCDD;
        do_cycle(0);
        dm_req = 1'b0; dm_wen = 4'b0000;
        do_cycle(0);

        // Flush in the response cycle, then flush together with the grant.
        if_req = 1'b1; if_addr = 32'h8;
        do_cycle(0);
        if_req = 1'b0; cancel = 1'b1;
        do_cycle(0);
        if_req = 1'b1; if_addr = 32'h24; cancel = 1'b1;
        do_cycle(0);
        if_req = 1'b0; cancel = 1'b0;
        do_cycle(0);

        // Both held for 10 cycles: data wins until fetch starves.
        if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_wen = 4'b0000; dm_addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            do_cycle(0);
            if (e_dm_gnt) dm_addr = dm_addr + 32'h4;
            if (e_if_gnt) if_addr = if_addr + 32'h4;
        end
        if_req = 1'b0; dm_req = 1'b0;
        do_cycle(0);

        // Random traffic at rising load levels.
        for (int p = 0; p < 3; p++) begin
            req_pct = (p == 0) ? 30 : ((p == 1) ? 70 : 100);
            for (int c = 0; c < 600; c++) do_cycle(1);
        end
        if_req = 1'b0; dm_req = 1'b0; cancel = 1'b0;
        do_cycle(0);

        // Asynchronous reset between a load grant and its response.
        dm_req = 1'b1; dm_wen = 4'b0000; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #2;
        resetn = 1'b0;
        #1;
        check("arst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check("arst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("arst_dm_gnt", 32'(dm_gnt), 32'd0);
        check("arst_if_gnt", 32'(if_gnt), 32'd0);
        check("arst_ram_en", 32'(ram_en), 32'd0);
        reset_model();
        check_stats();
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        do_cycle(0);
        req_pct = 100;
        for (int c = 0; c < 200; c++) do_cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
